btc_wb_ctrl: RTL and testbench

BTC_WB_CTRL -- requirements
Module: btc_wb_ctrl

---
 rtl/btc_pkg.sv | 34 +++
 rtl/btc_block_regs.sv | 36 +++
 rtl/btc_wb_ctrl.sv | 149 ++++++++++++++
 tb/tb_btc_wb_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/btc_pkg.sv
// Shared register map, field positions and controller state encoding for the
// SHA-256 Wishbone controller.
package btc_pkg;

    localparam int BLOCK_WORDS  = 16;
    localparam int DIGEST_WORDS = 8;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_BLOCK  = 8'h40;
    localparam logic [7:0] OFF_DIGEST = 8'h80;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } btc_state_e;

    // 0x40-0x7C, word aligned
    function automatic logic is_block_off(input logic [7:0] off);
        return (off[7:6] == OFF_BLOCK[7:6]) && (off[1:0] == 2'b00);
    endfunction

    // 0x80-0x9C, word aligned
    function automatic logic is_digest_off(input logic [7:0] off);
        return (off[7:5] == OFF_DIGEST[7:5]) && (off[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/btc_block_regs.sv
// 16x32 message block store with per-byte write enables; presents the whole
// block flat, word 0 in the top 32 bits.
module btc_block_regs
    import btc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [3:0]   idx,
    input  logic [3:0]   be,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic [511:0] block
);

    logic [31:0] words [BLOCK_WORDS];

    // NOTE: this storage is reset word by word because software may launch a
    // hash without rewriting every word; a reset-less RAM would leak stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_WORDS; i++) words[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) words[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = words[idx];

    always_comb begin
        for (int i = 0; i < BLOCK_WORDS; i++) block[511-32*i -: 32] = words[i];
    end

endmodule

// File: rtl/btc_wb_ctrl.sv
// Wishbone classic slave controlling a SHA-256 core: block load, start, digest
// capture and done interrupt. Define BTC_WB_CTRL_IRQ_EN to build the interrupt.
module btc_wb_ctrl
    import btc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_dat_i,
    input  logic [31:0]  wbs_adr_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic         sha_start_o,
    output logic [511:0] sha_block_o,
    input  logic         sha_ready_i,
    input  logic         sha_digest_valid_i,
    input  logic [255:0] sha_digest_i,
    output logic         irq_o
);

    btc_state_e  state;
    logic        start_pend;
    logic        done;
    logic        irq_en;
    logic [31:0] digest [DIGEST_WORDS];
    logic [31:0] blk_rdata;
    logic [31:0] rdata;

    logic [7:0] offset;
    logic       hit, wr, rd;
    logic       is_ctrl, is_status, is_block, is_digest;
    logic       busy, start_req, blk_we, done_clr, capture;

    // The pending-ack term keeps a held strobe from being acked twice.
    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign wr        = hit & wbs_we_i;
    assign rd        = hit & ~wbs_we_i;
    assign offset    = wbs_adr_i[7:0];
    assign is_ctrl   = (offset == OFF_CTRL);
    assign is_status = (offset == OFF_STATUS);
    assign is_block  = is_block_off(offset);
    assign is_digest = is_digest_off(offset);

    assign busy      = (state != ST_IDLE) | start_pend;
    assign start_req = wr & is_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_START_BIT] & ~busy;
    assign blk_we    = wr & is_block & ~busy;
    assign done_clr  = wr & is_status & wbs_dat_i[STATUS_DONE_BIT];
    assign capture   = (state == ST_WAIT) & sha_digest_valid_i;

    assign sha_start_o = (state == ST_LAUNCH);

    btc_block_regs u_block (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .we    (blk_we),
        .idx   (offset[5:2]),
        .be    (wbs_sel_i),
        .wdata (wbs_dat_i),
        .rdata (blk_rdata),
        .block (sha_block_o)
    );

    // NOTE: state registers use <= so every flop samples pre-edge values;
    // blocking assignments here would make results depend on block order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            start_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req || start_pend) begin
                        if (sha_ready_i) begin
                            state      <= ST_LAUNCH;
                            start_pend <= 1'b0;
                        end else begin
                            start_pend <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH: state <= ST_WAIT;
                ST_WAIT:   if (sha_digest_valid_i) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // A capture wins over a coincident write-1-to-clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            done <= 1'b0;
            for (int i = 0; i < DIGEST_WORDS; i++) digest[i] <= '0;
        end else begin
            if (capture) begin
                done <= 1'b1;
                for (int i = 0; i < DIGEST_WORDS; i++) digest[i] <= sha_digest_i[255-32*i -: 32];
            end else if ((state == ST_LAUNCH) || done_clr) begin
                done <= 1'b0;
            end
        end
    end

`ifdef BTC_WB_CTRL_IRQ_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (wr && is_ctrl && wbs_sel_i[0]) irq_en <= wbs_dat_i[CTRL_IRQ_EN_BIT];
            irq_o <= done & irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    // NOTE: rdata gets a default before the decode so unmatched offsets
    // cannot infer a latch.
    always_comb begin
        rdata = '0;
        if (is_ctrl) begin
            rdata[CTRL_IRQ_EN_BIT] = irq_en;
        end else if (is_status) begin
            rdata[STATUS_BUSY_BIT] = busy;
            rdata[STATUS_DONE_BIT] = done;
        end else if (is_block) begin
            rdata = blk_rdata;
        end else if (is_digest) begin
            rdata = digest[offset[4:2]];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= rd ? rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_btc_wb_ctrl.sv
// Scoreboard bench for btc_wb_ctrl: bus tasks queue expected read data, a
// monitor pops and compares on each ack.
module tb_btc_wb_ctrl;

`ifdef BTC_WB_CTRL_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic         clk = 0, rst = 1;
    logic         stb = 0, cyc = 0, we = 0;
    logic [3:0]   sel = 0;
    logic [31:0]  dat_i = 0, adr = 0;
    logic         ack;
    logic [31:0]  dat_o;
    logic         sha_start;
    logic [511:0] sha_block;
    logic         sha_ready = 1;
    logic         dig_valid = 0;
    logic [255:0] digest = 0;
    logic         irq;

    btc_wb_ctrl #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .sha_start_o(sha_start), .sha_block_o(sha_block),
        .sha_ready_i(sha_ready), .sha_digest_valid_i(dig_valid),
        .sha_digest_i(digest), .irq_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   start_cnt = 0;
    bit   irq_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sha_start) start_cnt++;
        if (irq) irq_seen = 1;
        if (ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_read) check(e.name, dat_o, e.data);
            end
        end
    end

    task automatic wb_cycle(input bit w, input logic [7:0] off, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] exp, input string name);
        int n;
        exp_t e;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = BASE | {24'h0, off}; dat_i = d; sel = s;
        e.is_read = !w; e.data = exp; e.name = name;
        sb.push_back(e);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 20);
        check({name, "_ack_lat"}, n, 1);
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        check({name, "_ack_drop"}, {31'h0, ack}, 0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s, input string name);
        wb_cycle(1'b1, off, d, s, 32'h0, name);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
        wb_cycle(1'b0, off, 32'h0, 4'hF, exp, name);
    endtask

    task automatic pulse_digest(input logic [31:0] w0, input logic [31:0] w7);
        @(posedge clk); #1;
        digest = {w0, 192'h0, w7};
        dig_valid = 1;
        @(posedge clk); #1;
        dig_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset state
        idle(2);
        check("rst_ack", {31'h0, ack}, 0);
        check("rst_dat", dat_o, 0);
        check("rst_start", {31'h0, sha_start}, 0);
        check("rst_irq", {31'h0, irq}, 0);
        rst = 0;
        idle(1);
        rd(8'h04, 32'h0, "status_reset");
        check("irq_after_reset", {31'h0, irq}, 0);

        // Byte-enabled block write
        wr(8'h40, 32'h6162_6380, 4'b0011, "blk0_wr");
        rd(8'h40, 32'h0000_6380, "blk0_rd");
        check("sha_block_w0", sha_block[511:480], 32'h0000_6380);
        wr(8'h7C, 32'hDEAD_BEEF, 4'hF, "blk15_wr");
        check("sha_block_w15", sha_block[31:0], 32'hDEAD_BEEF);

        // Unmapped offset and foreign address
        wr(8'h20, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
        rd(8'h20, 32'h0, "unmapped_rd");
        @(posedge clk); #1;
        cyc = 1; stb = 1; adr = 32'h3100_0004; sel = 4'hF;
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
        cyc = 0; stb = 0;
        check("foreign_no_ack", n, 0);

        // IRQ_EN then START
        wr(8'h00, 32'h2, 4'hF, "ctrl_irqen_wr");
        rd(8'h00, IRQ ? 32'h2 : 32'h0, "ctrl_rd");
        wr(8'h00, 32'h3, 4'hF, "start_wr");
        check("start_pulse1", start_cnt, 1);
        rd(8'h04, 32'h1, "status_busy");

        // Writes while busy are acked but ignored
        wr(8'h40, 32'hFFFF_FFFF, 4'hF, "blk0_busy_wr");
        wr(8'h00, 32'h3, 4'hF, "start_busy_wr");
        rd(8'h40, 32'h0000_6380, "blk0_busy_rd");
        idle(2);
        check("no_second_start", start_cnt, 1);

        // Digest capture
        pulse_digest(32'hBA78_16BF, 32'hF200_15AD);
        rd(8'h80, 32'hBA78_16BF, "digest0");
        rd(8'h9C, 32'hF200_15AD, "digest7");
        rd(8'h04, 32'h2, "status_done");
        check("irq_done", {31'h0, irq}, {31'h0, IRQ});

        // W1C DONE
        wr(8'h04, 32'h2, 4'hF, "done_w1c");
        idle(1);
        check("irq_cleared", {31'h0, irq}, 0);
        rd(8'h04, 32'h0, "status_cleared");

        // Digest strobe in IDLE is ignored
        pulse_digest(32'h1111_1111, 32'h2222_2222);
        rd(8'h80, 32'hBA78_16BF, "digest_idle_ignored");
        rd(8'h04, 32'h0, "status_idle_ignored");

        // Start held until the core is ready
        sha_ready = 0;
        wr(8'h00, 32'h3, 4'hF, "start_pend_wr");
        rd(8'h04, 32'h1, "status_pending");
        check("no_start_while_unready", start_cnt, 1);
        sha_ready = 1;
        idle(3);
        check("start_pulse2", start_cnt, 2);

        // Capture and W1C on the same edge: DONE ends set
        fork
            wr(8'h04, 32'h2, 4'hF, "w1c_vs_capture");
            pulse_digest(32'hCAFE_0001, 32'hCAFE_0007);
        join
        rd(8'h04, 32'h2, "status_set_wins");
        rd(8'h80, 32'hCAFE_0001, "digest0_second");

        // Reset in WAIT drops the in-flight digest
        wr(8'h00, 32'h3, 4'hF, "start3_wr");
        check("start_pulse3", start_cnt, 3);
        @(posedge clk); #1;
        rst = 1;
        idle(2);
        rst = 0;
        pulse_digest(32'h5555_5555, 32'h6666_6666);
        rd(8'h80, 32'h0, "digest_after_rst");
        rd(8'h04, 32'h0, "status_after_rst");
        rd(8'h40, 32'h0, "blk0_after_rst");
        rd(8'h00, 32'h0, "ctrl_after_rst");
        check("irq_after_rst", {31'h0, irq}, 0);

        idle(2);
        check("sb_drained", sb.size(), 0);
        if (!IRQ) check("irq_never", {31'h0, irq_seen}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
